i2c_target: RTL and testbench
=============================

# i2c_target

I2C target (slave) byte engine: the responder end of the I2C link whose initiator side generates SCL from a divided system clock. Oversamples SCL/SDA on clk, detects START/STOP, matches a fixed 7-bit address, ACKs, and delivers write bytes to or fetches read bytes from the local register logic. SDA is open-drain; the block only asserts a pull-low enable.

## Interface
- ADDR, 7'h50: 7-bit target address.
- SYNC_STAGES, 2: synchronizer depth for scl_i/sda_i (≥2).
- clk  in  1  system clock; must be ≥8× SCL frequency.
- rst_n  in  1  reset, asynchronous, active-low; clock clk.
- scl_i  in  1  raw SCL from pad.
- sda_i  in  1  raw SDA from pad.
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- rx_data  out  8  last received write byte, MSB first on wire.
- rx_valid  out  1  1-cycle pulse; rx_data updated this cycle.
- tx_data  in  8  read byte; sampled only in the cycle tx_ld = 1.
- tx_ld  out  1  1-cycle pulse; tx_data captured this cycle.
- busy  out  1  1 from address match until STOP/NACK/mismatch.
- rd_mode  out  1  R/W bit of the matched address byte.

## Operation
- Front end: scl_i/sda_i synchronized, then edge-detected on synchronized SCL (scl_rise, scl_fall).
- START: SDA 1→0 while SCL high in both previous and current sample. STOP: SDA 1→0 reversed (0→1) under same condition. If SCL and SDA change in the same sample, no START/STOP; SCL edge takes effect.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
- START in any state → ADDR, bit counter 0, sda_oe 0 same cycle (repeated START). STOP in any state → IDLE, sda_oe 0, busy 0.
- Bit counter 3 bits, increments on scl_rise, wraps 7→0; shift register left-shifts SDA on scl_rise.
- ADDR: on 8th scl_rise, if shift[7:1]==ADDR → ADDR_ACK, busy 1, rd_mode = bit 0; else → IDLE (ignores bus until next START). Address 7'h00 not special.
- ADDR_ACK: next scl_fall sets sda_oe 1; following scl_fall releases ACK → WR_DATA (rd_mode 0) or RD_DATA (rd_mode 1).
- WR_DATA: on 8th scl_rise rx_data ← byte, rx_valid pulses → WR_ACK; ACK driven as in ADDR_ACK, then → WR_DATA. Target always ACKs write bytes.
- RD_DATA: in the scl_fall cycle that ends the preceding ACK, tx_ld pulses, byte loaded, sda_oe = ~tx_data[7] same cycle; each later scl_fall shifts next bit; after 8th bit's scl_fall sda_oe 0 → RD_ACK.
- RD_ACK: on scl_rise SDA 0 (ACK) → RD_DATA (next scl_fall reloads via tx_ld); SDA 1 (NACK) → IDLE, busy 0.

## Timing
- Reset values: sda_oe 0, rx_data 8'h00, rx_valid 0, tx_ld 0, busy 0, rd_mode 0; synchronizer flops reset to 1 (idle bus).
- scl_i edge → internal scl_rise/scl_fall: SYNC_STAGES+1 cycles (filter adds 2, see Configuration).
- rx_valid: registered, same cycle as rx_data update, one cycle after scl_rise detection.
- sda_oe: registered, changes one cycle after scl_fall detection; never changes on scl_rise.
- Reset mid-transfer: outputs return to reset values immediately; bus released.

## Configuration
- I2C_TARGET_GLITCH_FILTER_EN defined: 3-sample majority filter after synchronizer on both lines; pulses ≤1 clk suppressed; edge latency +2 cycles.
- Undefined: synchronizer output used directly; single-cycle glitches seen as edges.

## Structure
- i2c_pkg: state enum typedef i2c_tgt_state_t, constants I2C_ACK = 1'b0, I2C_NACK = 1'b1, I2C_BITS = 8.
- Sub-module i2c_sync_filter: synchronizer, optional majority filter, edge/START/STOP detection; one instance per target.

## Test plan
- Write to 0x50, bytes 0xA5, 0x3C, STOP → ACK on all three 9th bits; rx_valid twice with 0xA5 then 0x3C; busy 0 after STOP.
- Address 0x51 write → no ACK (SDA high on 9th bit), no rx_valid, busy stays 0.
- Read from 0x50, tx_data 0x96 then 0x0F, master ACK then NACK → SDA bits 10010110, 00001111; tx_ld pulses twice; busy 0 after NACK.
- Write 0x50 + byte 0x11, repeated START, read 0x50 → rx_valid once, rd_mode 1 after second address, tx_ld pulse.
- STOP injected mid-byte (bit 4 of write) → sda_oe 0, IDLE, no rx_valid; rst_n low mid-read → all outputs reset values.
- 1-clk SDA glitch while SCL high: with I2C_TARGET_GLITCH_FILTER_EN no START/STOP; without, false STOP → IDLE.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target byte engine.
package i2c_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrData,
        StWrAck,
        StRdData,
        StRdAck
    } i2c_tgt_state_t;

    localparam logic        I2C_ACK  = 1'b0;
    localparam logic        I2C_NACK = 1'b1;
    localparam int unsigned I2C_BITS = 8;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/i2c_sync_filter.sv
// SCL/SDA synchronizer with edge, START and STOP detection.
// Define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample majority filter on both lines.
module i2c_sync_filter
    import i2c_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop,
    output logic o_sda
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   w_scl;
    logic                   w_sda;
    logic                   r_scl_q;
    logic                   r_sda_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [2:0] r_scl_flt;
    logic [2:0] r_sda_flt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_flt <= '1;
            r_sda_flt <= '1;
        end else begin
            r_scl_flt <= {r_scl_flt[1:0], r_scl_sync[SYNC_STAGES-1]};
            r_sda_flt <= {r_sda_flt[1:0], r_sda_sync[SYNC_STAGES-1]};
        end
    end

    assign w_scl = maj3(r_scl_flt);
    assign w_sda = maj3(r_sda_flt);
`else
    assign w_scl = r_scl_sync[SYNC_STAGES-1];
    assign w_sda = r_sda_sync[SYNC_STAGES-1];
`endif

    // A simultaneous SCL change defeats the SCL-high-twice term, so it reads as an edge only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_q    <= 1'b1;
            r_sda_q    <= 1'b1;
            o_scl_rise <= 1'b0;
            o_scl_fall <= 1'b0;
            o_start    <= 1'b0;
            o_stop     <= 1'b0;
        end else begin
            r_scl_q    <= w_scl;
            r_sda_q    <= w_sda;
            o_scl_rise <= w_scl & ~r_scl_q;
            o_scl_fall <= ~w_scl & r_scl_q;
            o_start    <= r_scl_q & w_scl & r_sda_q & ~w_sda;
            o_stop     <= r_scl_q & w_scl & ~r_sda_q & w_sda;
        end
    end

    // Aligned with the registered pulses: the SDA level seen at the detected edge.
    assign o_sda = r_sda_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target byte engine: address match, ACK, write-byte delivery and read-byte fetch.
// Optional glitch filter via I2C_TARGET_GLITCH_FILTER_EN (see i2c_sync_filter).
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  ADDR        = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ld,
    output logic       busy,
    output logic       rd_mode
);

    logic           w_scl_rise;
    logic           w_scl_fall;
    logic           w_start;
    logic           w_stop;
    logic           w_sda;
    logic [7:0]     w_byte;
    logic           w_tx_ld;
    i2c_tgt_state_t r_state;
    logic [2:0]     r_cnt;
    logic [6:0]     r_shift;
    logic [6:0]     r_tx_shift;
    logic           r_ack_on;
    logic           r_pend;

    i2c_sync_filter #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_scl     (scl_i),
        .i_sda     (sda_i),
        .o_scl_rise(w_scl_rise),
        .o_scl_fall(w_scl_fall),
        .o_start   (w_start),
        .o_stop    (w_stop),
        .o_sda     (w_sda)
    );

    assign w_byte  = {r_shift, w_sda};
    // Byte fetch happens on the SCL fall that closes the preceding ACK bit.
    assign w_tx_ld = w_scl_fall &
                     (((r_state == StAddrAck) && r_ack_on && rd_mode) ||
                      ((r_state == StRdData) && r_pend));
    assign tx_ld   = w_tx_ld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_tx_shift <= '0;
            r_ack_on   <= 1'b0;
            r_pend     <= 1'b0;
            sda_oe     <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            busy       <= 1'b0;
            rd_mode    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (w_stop) begin
                r_state  <= StIdle;
                r_ack_on <= 1'b0;
                r_pend   <= 1'b0;
                sda_oe   <= 1'b0;
                busy     <= 1'b0;
            end else if (w_start) begin
                r_state  <= StAddr;
                r_cnt    <= '0;
                r_ack_on <= 1'b0;
                r_pend   <= 1'b0;
                sda_oe   <= 1'b0;
            end else begin
                if (w_scl_rise) begin
                    r_shift <= w_byte[6:0];
                    r_cnt   <= r_cnt + 3'd1;
                end
                unique case (r_state)
                    StIdle: ;
                    StAddr: begin
                        if (w_scl_rise && r_cnt == 3'(I2C_BITS - 1)) begin
                            if (w_byte[7:1] == ADDR) begin
                                r_state <= StAddrAck;
                                busy    <= 1'b1;
                                rd_mode <= w_byte[0];
                            end else begin
                                r_state <= StIdle;
                                busy    <= 1'b0;
                            end
                        end
                    end
                    StAddrAck, StWrAck: begin
                        if (w_scl_fall) begin
                            if (!r_ack_on) begin
                                r_ack_on <= 1'b1;
                                sda_oe   <= (I2C_ACK == 1'b0);
                            end else begin
                                r_ack_on <= 1'b0;
                                r_cnt    <= '0;
                                if (w_tx_ld) begin
                                    r_state    <= StRdData;
                                    r_tx_shift <= tx_data[6:0];
                                    sda_oe     <= ~tx_data[7];
                                end else begin
                                    r_state <= StWrData;
                                    sda_oe  <= 1'b0;
                                end
                            end
                        end
                    end
                    StWrData: begin
                        if (w_scl_rise && r_cnt == 3'(I2C_BITS - 1)) begin
                            rx_data  <= w_byte;
                            rx_valid <= 1'b1;
                            r_state  <= StWrAck;
                        end
                    end
                    StRdData: begin
                        if (w_scl_fall) begin
                            if (r_pend) begin
                                r_pend     <= 1'b0;
                                r_cnt      <= '0;
                                r_tx_shift <= tx_data[6:0];
                                sda_oe     <= ~tx_data[7];
                            end else if (r_cnt == 3'd0) begin
                                // Counter wrapped: all eight bits have been clocked out.
                                sda_oe  <= 1'b0;
                                r_state <= StRdAck;
                            end else begin
                                sda_oe     <= ~r_tx_shift[6];
                                r_tx_shift <= {r_tx_shift[5:0], 1'b0};
                            end
                        end
                    end
                    StRdAck: begin
                        if (w_scl_rise) begin
                            if (w_sda == I2C_ACK) begin
                                r_state <= StRdData;
                                r_pend  <= 1'b1;
                            end else begin
                                r_state <= StIdle;
                                busy    <= 1'b0;
                            end
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: bus-level master tasks plus a transaction-level model.
module tb_i2c_target;

    localparam int         T     = 60;
    localparam logic [6:0] TADDR = 7'h50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic [7:0] tx_data = 8'h00;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_ld;
    logic       busy;
    logic       rd_mode;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_rx[$];
    int         tx_ld_cnt = 0;
    int         exp_tx_ld = 0;

    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target #(
        .ADDR       (TADDR),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .scl_i   (scl_m),
        .sda_i   (sda_bus),
        .sda_oe  (sda_oe),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_ld   (tx_ld),
        .busy    (busy),
        .rd_mode (rd_mode)
    );

    always @(negedge clk) begin
        if (rx_valid) rx_q.push_back(rx_data);
        if (tx_ld) tx_ld_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rx();
        check("rx_count", rx_q.size(), exp_rx.size());
        for (int i = 0; i < rx_q.size() && i < exp_rx.size(); i++)
            check("rx_byte", rx_q[i], exp_rx[i]);
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        scl_m = 1'b0; #(T);
        sda_m = b;    #(T);
        scl_m = 1'b1; #(T);
        s = sda_bus;  #(T);
    endtask

    task automatic start_cond();
        scl_m = 1'b0; #(T);
        sda_m = 1'b1; #(T);
        scl_m = 1'b1; #(T);
        sda_m = 1'b0; #(T);
    endtask

    task automatic stop_cond();
        scl_m = 1'b0; #(T);
        sda_m = 1'b0; #(T);
        scl_m = 1'b1; #(T);
        sda_m = 1'b1; #(2 * T);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic [7:0] txd, input logic m_ack, output logic [7:0] d);
        logic s;
        tx_data = txd;
        for (int i = 7; i >= 0; i--) bit_xfer(1'b1, d[i]);
        bit_xfer(m_ack ? 1'b0 : 1'b1, s);
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d[4], input int n);
        logic ack;
        logic match;
        match = (a == TADDR);
        start_cond();
        write_byte({a, 1'b0}, ack);
        check("wr_addr_ack", ack, match ? 0 : 1);
        check("wr_busy_addr", busy, match ? 1 : 0);
        for (int i = 0; i < n; i++) begin
            write_byte(d[i], ack);
            check("wr_data_ack", ack, match ? 0 : 1);
            if (match) exp_rx.push_back(d[i]);
        end
        stop_cond();
        check("wr_busy_stop", busy, 0);
        check_rx();
    endtask

    task automatic do_read(input logic [6:0] a, input logic [7:0] d[4], input int n);
        logic       ack;
        logic [7:0] got;
        start_cond();
        write_byte({a, 1'b1}, ack);
        check("rd_addr_ack", ack, (a == TADDR) ? 0 : 1);
        if (a == TADDR) begin
            check("rd_mode", rd_mode, 1);
            for (int i = 0; i < n; i++) begin
                read_byte(d[i], i != n - 1, got);
                check("rd_byte", got, d[i]);
                exp_tx_ld++;
            end
        end
        check("rd_busy_end", busy, 0);
        stop_cond();
        check("tx_ld_count", tx_ld_cnt, exp_tx_ld);
    endtask

    initial begin
        logic [7:0] d[4];
        logic [7:0] got;
        logic       ack;
        logic       s;
        logic [7:0] gbyte;

        #1;
        check("rst_sda_oe", sda_oe, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_ld", tx_ld, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_mode", rd_mode, 0);
        #50 rst_n = 1'b1;
        #100;

        d = '{8'hA5, 8'h3C, 8'h00, 8'h00};
        do_write(TADDR, d, 2);

        d = '{8'($urandom), 8'h00, 8'h00, 8'h00};
        do_write(7'h51, d, 1);

        d = '{8'h96, 8'h0F, 8'h00, 8'h00};
        do_read(TADDR, d, 2);

        // Write then repeated START into a read.
        start_cond();
        write_byte({TADDR, 1'b0}, ack);
        check("rs_addr_ack", ack, 0);
        write_byte(8'h11, ack);
        check("rs_data_ack", ack, 0);
        exp_rx.push_back(8'h11);
        start_cond();
        write_byte({TADDR, 1'b1}, ack);
        check("rs_raddr_ack", ack, 0);
        check("rs_rd_mode", rd_mode, 1);
        gbyte = 8'($urandom);
        read_byte(gbyte, 1'b0, got);
        exp_tx_ld++;
        check("rs_rd_byte", got, gbyte);
        stop_cond();
        check_rx();
        check("rs_tx_ld", tx_ld_cnt, exp_tx_ld);

        // STOP in the middle of a write byte.
        start_cond();
        write_byte({TADDR, 1'b0}, ack);
        check("ms_addr_ack", ack, 0);
        for (int i = 0; i < 4; i++) bit_xfer(1'($urandom), s);
        stop_cond();
        check("ms_sda_oe", sda_oe, 0);
        check("ms_busy", busy, 0);
        check_rx();

        // Reset asserted while the target is driving a read bit.
        start_cond();
        write_byte({TADDR, 1'b1}, ack);
        check("rr_addr_ack", ack, 0);
        tx_data = 8'h00;
        bit_xfer(1'b1, s);
        bit_xfer(1'b1, s);
        exp_tx_ld++;
        scl_m = 1'b0;
        #(T);
        check("rr_driving", sda_oe, 1);
        rst_n = 1'b0;
        #1;
        check("rr_sda_oe", sda_oe, 0);
        check("rr_rx_data", rx_data, 0);
        check("rr_rx_valid", rx_valid, 0);
        check("rr_tx_ld", tx_ld, 0);
        check("rr_busy", busy, 0);
        check("rr_rd_mode", rd_mode, 0);
        #(T);
        rst_n = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        #(4 * T);
        check("rr_tx_ld_cnt", tx_ld_cnt, exp_tx_ld);

        // One-clock SDA low glitch while SCL is high, on the MSB of a data byte.
        start_cond();
        write_byte({TADDR, 1'b0}, ack);
        check("gl_addr_ack", ack, 0);
        gbyte = {1'b1, 7'($urandom)};
        scl_m = 1'b0; #(T);
        sda_m = 1'b1; #(T);
        scl_m = 1'b1; #(T);
        @(negedge clk) sda_m = 1'b0;
        @(negedge clk) sda_m = 1'b1;
        #(T);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        check("gl_busy", busy, 1);
`else
        check("gl_busy", busy, 0);
`endif
        for (int i = 6; i >= 0; i--) bit_xfer(gbyte[i], s);
        bit_xfer(1'b1, ack);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        check("gl_data_ack", ack, 0);
        exp_rx.push_back(gbyte);
`else
        check("gl_data_ack", ack, 1);
`endif
        stop_cond();
        check("gl_busy_stop", busy, 0);
        check_rx();

        for (int k = 0; k < 8; k++) begin
            logic [6:0] a;
            int         n;
            a = ($urandom_range(0, 1) == 1) ? TADDR : 7'($urandom_range(0, 127));
            n = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) do_read(a, d, n);
            else do_write(a, d, n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
